// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the LED fade sequencer: state encoding,
// channel indices and the round-robin channel search.
package led_fade_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } fade_state_e;

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_RAMP_UP   = RAMP_UP;
  localparam logic [2:0] ST_HOLD_HIGH = HOLD_HIGH;
  localparam logic [2:0] ST_RAMP_DOWN = RAMP_DOWN;
  localparam logic [2:0] ST_HOLD_LOW  = HOLD_LOW;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;

  typedef struct packed {
    logic       found;
    logic       wrap;
    logic [1:0] ch;
  } chan_sel_t;

  // Next set mask bit strictly after cur, wrapping blue -> red. Scanning from
  // the farthest candidate to the nearest lets the nearest one win.
  function automatic chan_sel_t next_channel(input logic [2:0] mask, input logic [1:0] cur);
    chan_sel_t  sel;
    logic [2:0] pos;
    logic [1:0] idx;
    sel = '0;
    for (int k = 3; k >= 1; k--) begin
      pos = {1'b0, cur} + 3'(k);
      idx = (pos >= 3'd3) ? 2'(pos - 3'd3) : pos[1:0];
      if (mask[idx]) begin
        sel.found = 1'b1;
        sel.wrap  = (pos >= 3'd3);
        sel.ch    = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/led_fade_sequencer_tick_gen.sv
// Step-tick prescaler: one-clock tick every CLK_DIV clocks, held at zero
// while clear is high.
module fade_tick_gen #(
  parameter int CLK_DIV = 4096
) (
  input  logic clock_12mhz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) count_d = '0;
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/led_fade_sequencer.sv
// RGB fade sequencer: ramps each enabled channel up, holds, ramps down, holds,
// then moves round-robin. `define LED_FADE_PWM_EN adds active-low PWM LED outputs.
module led_fade_sequencer
  import led_fade_pkg::*;
#(
  parameter int CLK_DIV    = 4096,
  parameter int HOLD_STEPS = 64,
  parameter int DUTY_MAX   = 255
) (
  input  logic              clock_12mhz,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        channel_mask,
  output logic [DUTY_W-1:0] duty_red,
  output logic [DUTY_W-1:0] duty_green,
  output logic [DUTY_W-1:0] duty_blue,
  output logic [1:0]        active_channel,
  output logic              busy,
  output logic              cycle_done,
  output logic [2:0]        dbg_state
`ifdef LED_FADE_PWM_EN
  ,
  output logic              led_red,
  output logic              led_green,
  output logic              led_blue
`endif
);

  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [DUTY_W-1:0] DUTY_TOP  = DUTY_W'(DUTY_MAX);

  logic [2:0]        state_q, state_d;
  logic [1:0]        active_q, active_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tick, tick_clear;
  chan_sel_t         sel_next;

  assign tick_clear = (state_q == ST_IDLE) || !enable;

  fade_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .clear       (tick_clear),
    .tick        (tick)
  );

  // Searching "after blue" from IDLE yields the lowest set bit.
  assign sel_next = next_channel(channel_mask, (state_q == ST_IDLE) ? CH_BLUE : active_q);

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    duty_d     = duty_q;
    hold_d     = hold_q;
    cycle_done = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_next.found) begin
            state_d  = ST_RAMP_UP;
            active_d = sel_next.ch;
            duty_d   = '0;
            hold_d   = '0;
          end
        end
        ST_RAMP_UP: begin
          if (tick) begin
            if (duty_q == DUTY_TOP) begin
              state_d = ST_HOLD_HIGH;
              hold_d  = '0;
            end else begin
              duty_d = duty_q + 1'b1;
            end
          end
        end
        ST_HOLD_HIGH: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) state_d = ST_RAMP_DOWN;
            else                     hold_d  = hold_q + 1'b1;
          end
        end
        ST_RAMP_DOWN: begin
          if (tick) begin
            if (duty_q == '0) begin
              state_d = ST_HOLD_LOW;
              hold_d  = '0;
            end else begin
              duty_d = duty_q - 1'b1;
            end
          end
        end
        ST_HOLD_LOW: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              duty_d = '0;
              if (!sel_next.found) begin
                state_d = ST_IDLE;
              end else begin
                state_d    = ST_RAMP_UP;
                active_d   = sel_next.ch;
                hold_d     = '0;
                cycle_done = sel_next.wrap;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= CH_RED;
      duty_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      duty_q   <= duty_d;
      hold_q   <= hold_d;
    end
  end

  assign duty_red       = (active_q == CH_RED)   ? duty_q : '0;
  assign duty_green     = (active_q == CH_GREEN) ? duty_q : '0;
  assign duty_blue      = (active_q == CH_BLUE)  ? duty_q : '0;
  assign active_channel = active_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state      = state_q;

`ifdef LED_FADE_PWM_EN
  logic [7:0] pwm_count_q, pwm_count_d;
  logic       led_red_q, led_green_q, led_blue_q;
  logic       led_red_d, led_green_d, led_blue_d;

  always_comb begin
    pwm_count_d = pwm_count_q + 1'b1;
    led_red_d   = !(pwm_count_q < duty_red);
    led_green_d = !(pwm_count_q < duty_green);
    led_blue_d  = !(pwm_count_q < duty_blue);
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      pwm_count_q <= '0;
      led_red_q   <= 1'b1;
      led_green_q <= 1'b1;
      led_blue_q  <= 1'b1;
    end else begin
      pwm_count_q <= pwm_count_d;
      led_red_q   <= led_red_d;
      led_green_q <= led_green_d;
      led_blue_q  <= led_blue_d;
    end
  end

  assign led_red   = led_red_q;
  assign led_green = led_green_q;
  assign led_blue  = led_blue_q;
`endif

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer with a tick-count reference model.
module tb_led_fade_sequencer;

  localparam int CLK_DIV = 4;
  localparam int HOLD    = 2;
  localparam int DMAX    = 3;
  localparam int PERIOD  = 2 * (DMAX + 1) + 2 * HOLD;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] channel_mask;
  logic [7:0] duty_red, duty_green, duty_blue;
  logic [1:0] active_channel;
  logic       busy, cycle_done;
  logic [2:0] dbg_state;
`ifdef LED_FADE_PWM_EN
  logic       led_red, led_green, led_blue;
  logic       p_reset, p_enable;
  logic [2:0] p_mask;
  logic [7:0] p_duty_red, p_duty_green, p_duty_blue;
  logic [1:0] p_active;
  logic       p_busy, p_cycle_done, p_led_red, p_led_green, p_led_blue;
  logic [2:0] p_dbg_state;
`endif

  always #5 clk = ~clk;

  led_fade_sequencer #(.CLK_DIV(CLK_DIV), .HOLD_STEPS(HOLD), .DUTY_MAX(DMAX)) dut (
    .clock_12mhz(clk), .reset(rst), .enable(enable), .channel_mask(channel_mask),
    .duty_red(duty_red), .duty_green(duty_green), .duty_blue(duty_blue),
    .active_channel(active_channel), .busy(busy), .cycle_done(cycle_done),
    .dbg_state(dbg_state)
`ifdef LED_FADE_PWM_EN
    , .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
`endif
  );

`ifdef LED_FADE_PWM_EN
  led_fade_sequencer #(.CLK_DIV(512), .HOLD_STEPS(2), .DUTY_MAX(255)) dut_pwm (
    .clock_12mhz(clk), .reset(p_reset), .enable(p_enable), .channel_mask(p_mask),
    .duty_red(p_duty_red), .duty_green(p_duty_green), .duty_blue(p_duty_blue),
    .active_channel(p_active), .busy(p_busy), .cycle_done(p_cycle_done),
    .dbg_state(p_dbg_state),
    .led_red(p_led_red), .led_green(p_led_green), .led_blue(p_led_blue)
  );
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: channel + ticks elapsed since that channel started.
  bit m_busy;
  int m_ch, m_k, m_pre;
  int cd_seen, busy_seen, nz_rg;

  function automatic int exp_duty(input int k);
    if (k <= DMAX) return k;
    if (k <= DMAX + 1 + HOLD) return DMAX;
    if (k <= 2 * DMAX + 1 + HOLD) return 2 * DMAX + 1 + HOLD - k;
    return 0;
  endfunction

  function automatic int pick_next(input logic [2:0] m, input int cur, output bit wrap);
    int idx;
    wrap = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      idx = (cur + j) % 3;
      if (((m >> idx) & 3'd1) != 3'd0) begin
        wrap = ((cur + j) >= 3);
        return idx;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_ch = 0; m_k = 0; m_pre = 0;
  endtask

  // One clock: apply inputs, check outputs against the model, advance both.
  task automatic do_cycle(input logic en, input logic [2:0] m);
    int  er, eg, eb, nx;
    bit  ecd, w;
    enable = en;
    channel_mask = m;
    #1;
    ecd = 1'b0;
    if (m_busy && en && m_pre == CLK_DIV - 1 && m_k + 1 == PERIOD) begin
      nx  = pick_next(m, m_ch, w);
      ecd = (nx >= 0) && w;
    end
    er = (m_busy && m_ch == 0) ? exp_duty(m_k) : 0;
    eg = (m_busy && m_ch == 1) ? exp_duty(m_k) : 0;
    eb = (m_busy && m_ch == 2) ? exp_duty(m_k) : 0;
    checks += 6;
    if (duty_red !== 8'(er)) begin
      failures++; $display("FAIL duty_red t=%0t got=%0d exp=%0d", $time, duty_red, er);
    end
    if (duty_green !== 8'(eg)) begin
      failures++; $display("FAIL duty_green t=%0t got=%0d exp=%0d", $time, duty_green, eg);
    end
    if (duty_blue !== 8'(eb)) begin
      failures++; $display("FAIL duty_blue t=%0t got=%0d exp=%0d", $time, duty_blue, eb);
    end
    if (busy !== m_busy) begin
      failures++; $display("FAIL busy t=%0t got=%0b exp=%0b", $time, busy, m_busy);
    end
    if (active_channel !== 2'(m_ch)) begin
      failures++; $display("FAIL active_channel t=%0t got=%0d exp=%0d", $time, active_channel, m_ch);
    end
    if (cycle_done !== ecd) begin
      failures++; $display("FAIL cycle_done t=%0t got=%0b exp=%0b", $time, cycle_done, ecd);
    end
    if (cycle_done === 1'b1) cd_seen++;
    if (busy === 1'b1) busy_seen++;
    if (duty_red !== 8'd0 || duty_green !== 8'd0) nz_rg++;
    @(posedge clk);
    if (!en) begin
      m_busy = 1'b0; m_pre = 0;
    end else if (!m_busy) begin
      if (m != 3'b000) begin
        m_busy = 1'b1; m_ch = pick_next(m, 2, w); m_k = 0; m_pre = 0;
      end
    end else if (m_pre == CLK_DIV - 1) begin
      m_pre = 0;
      m_k++;
      if (m_k == PERIOD) begin
        nx = pick_next(m, m_ch, w);
        if (nx < 0) m_busy = 1'b0;
        else begin m_ch = nx; m_k = 0; end
      end
    end else begin
      m_pre++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    channel_mask = 3'b000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if ({duty_red, duty_green, duty_blue} !== 24'd0) begin
      failures++; $display("FAIL reset_duties got=%0h exp=0", {duty_red, duty_green, duty_blue});
    end
    if (active_channel !== 2'd0) begin failures++; $display("FAIL reset_active got=%0d exp=0", active_channel); end
    if (cycle_done !== 1'b0) begin failures++; $display("FAIL reset_cycle_done got=%0b exp=0", cycle_done); end
`ifdef LED_FADE_PWM_EN
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b111) begin
      failures++; $display("FAIL reset_leds got=%0b exp=111", {led_red, led_green, led_blue});
    end
`endif
  endtask

  task automatic test_all_channels();
    apply_reset();
    cd_seen = 0;
    // IDLE exit takes one clock, then tick n lands on clock 1 + 4n: tick 36 is clock 145.
    repeat (150) do_cycle(1'b1, 3'b111);
    checks++;
    if (cd_seen != 1) begin failures++; $display("FAIL all_channels_cd_count got=%0d exp=1", cd_seen); end
  endtask

  task automatic test_blue_only();
    apply_reset();
    cd_seen = 0; nz_rg = 0;
    repeat (150) do_cycle(1'b1, 3'b100);
    checks += 3;
    if (cd_seen != 3) begin failures++; $display("FAIL blue_only_cd_count got=%0d exp=3", cd_seen); end
    if (nz_rg != 0) begin failures++; $display("FAIL blue_only_red_green got=%0d exp=0", nz_rg); end
    if (active_channel !== 2'd2) begin failures++; $display("FAIL blue_only_active got=%0d exp=2", active_channel); end
  endtask

  task automatic test_zero_mask();
    apply_reset();
    busy_seen = 0;
    repeat (60) do_cycle(1'b1, 3'b000);
    checks++;
    if (busy_seen != 0) begin failures++; $display("FAIL zero_mask_busy got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_enable_drop();
    int guard;
    apply_reset();
    guard = 0;
    // Green ramping down with duty 2 is tick 7 of its period.
    while (!(m_busy && m_ch == 1 && m_k == 2 * DMAX + 1 + HOLD - 2) && guard < 500) begin
      do_cycle(1'b1, 3'b111);
      guard++;
    end
    checks++;
    if (guard >= 500) begin failures++; $display("FAIL enable_drop_reach got=timeout exp=green_ramp_down"); end
    cd_seen = 0;
    do_cycle(1'b0, 3'b111);
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL enable_drop_busy got=%0b exp=0", busy); end
    if (duty_green !== 8'd0) begin failures++; $display("FAIL enable_drop_duty got=%0d exp=0", duty_green); end
    if (cd_seen != 0) begin failures++; $display("FAIL enable_drop_cd got=%0d exp=0", cd_seen); end
    repeat (10) do_cycle(1'b0, 3'b111);
  endtask

  task automatic test_random();
    logic [2:0] m;
    logic       en;
    apply_reset();
    m = 3'($urandom_range(1, 7));
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 2) m = 3'($urandom_range(0, 7));
      do_cycle(en, m);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    apply_reset();
    guard = 0;
    while (!(m_busy && m_ch == 0 && m_k == 2) && guard < 100) begin
      do_cycle(1'b1, 3'b001);
      guard++;
    end
    checks += 2;
    if (guard >= 100) begin failures++; $display("FAIL reset_mid_reach got=timeout exp=duty_red_2"); end
    if (duty_red !== 8'd2) begin failures++; $display("FAIL reset_mid_pre got=%0d exp=2", duty_red); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if ({duty_red, duty_green, duty_blue} !== 24'd0) begin
      failures++; $display("FAIL reset_mid_duties got=%0h exp=0", {duty_red, duty_green, duty_blue});
    end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%0b exp=0", busy); end
    if (cycle_done !== 1'b0) begin failures++; $display("FAIL reset_mid_cd got=%0b exp=0", cycle_done); end
`ifdef LED_FADE_PWM_EN
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b111) begin
      failures++; $display("FAIL reset_mid_leds got=%0b exp=111", {led_red, led_green, led_blue});
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) do_cycle(1'b1, 3'b001);
  endtask

`ifdef LED_FADE_PWM_EN
  task automatic test_pwm();
    int guard, lows_r, lows_g;
    logic [7:0] d;
    p_mask = 3'b001;
    p_enable = 1'b1;
    guard = 0;
    while (p_duty_red !== 8'd64 && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 40000) begin failures++; $display("FAIL pwm_reach got=timeout exp=duty_64"); end
    for (int w = 0; w < 3; w++) begin
      d = p_duty_red;
      @(negedge clk);
      lows_r = 0; lows_g = 0;
      for (int i = 0; i < 256; i++) begin
        if (p_led_red === 1'b0) lows_r++;
        if (p_led_green === 1'b0) lows_g++;
        @(negedge clk);
      end
      checks += 2;
      if (lows_r != int'(d)) begin failures++; $display("FAIL pwm_red_low got=%0d exp=%0d", lows_r, d); end
      if (lows_g != 0) begin failures++; $display("FAIL pwm_green_low got=%0d exp=0", lows_g); end
      guard = 0;
      while (p_duty_red === d && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    channel_mask = 3'b000;
`ifdef LED_FADE_PWM_EN
    p_reset = 1'b1;
    p_enable = 1'b0;
    p_mask = 3'b000;
`endif
    model_reset();
    @(negedge clk);
`ifdef LED_FADE_PWM_EN
    p_reset = 1'b0;
`endif
    test_reset();
    test_all_channels();
    test_blue_only();
    test_zero_mask();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef LED_FADE_PWM_EN
    test_pwm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_fade_sequencer.md
Name: led_fade_sequencer

Overview:
- Sequences the on-board RGB LED through a fade pattern.
- Channels are visited round-robin (red, green, blue), skipping masked channels. Each visited channel is ramped 0 -> DUTY_MAX, held, ramped back to 0, then held again.
- Generates its own step tick from the system clock and drives an 8-bit duty value per channel. Sits between the clock/reset tree and the LED PWM stage.

Parameters:
- CLK_DIV, 4096: system clocks per step tick (12 MHz / 4096 ≈ 2.93 kHz); legal range >= 2.
- HOLD_STEPS, 64: ticks spent in each hold state; legal range >= 1.
- DUTY_MAX, 255: ramp ceiling; legal range 1..255.

Ports:
- clock_12mhz  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run the sequence when high; forced idle when low.
- channel_mask  input  3  bit0 = red, bit1 = green, bit2 = blue; 1 = channel participates.
- duty_red  output  8  red duty value.
- duty_green  output  8  green duty value.
- duty_blue  output  8  blue duty value.
- active_channel  output  2  0 = red, 1 = green, 2 = blue; 3 never driven.
- busy  output  1  high in any state other than IDLE.
- cycle_done  output  1  one-clock pulse when the sequence wraps past the last enabled channel.

Behaviour:
- Reset: all duties 0, active_channel 0, busy 0, cycle_done 0, state IDLE, prescaler 0, hold counter 0.
- Prescaler: cleared in IDLE; otherwise counts 0..CLK_DIV-1. tick = 1 for one clock when count == CLK_DIV-1, then the count wraps to 0.
- All state and duty updates below happen only on clocks where tick = 1, except the enable and IDLE exits.
- IDLE:
  - Leaves when enable = 1 and channel_mask != 0.
  - Next clock: state = RAMP_UP, active_channel = lowest set mask bit, all duties 0.
- RAMP_UP: on tick, if duty == DUTY_MAX go to HOLD_HIGH with hold counter = 0; else duty += 1.
- HOLD_HIGH: on tick, if hold counter == HOLD_STEPS-1 go to RAMP_DOWN; else hold counter += 1.
- RAMP_DOWN: on tick, if duty == 0 go to HOLD_LOW with hold counter = 0; else duty -= 1.
- HOLD_LOW: on tick at hold counter == HOLD_STEPS-1:
  - Select the next set mask bit strictly after active_channel, wrapping from blue to red.
  - If the search wraps, or the only set bit is the current channel, pulse cycle_done in that same clock.
  - If the sampled mask is 0, go to IDLE; otherwise go to RAMP_UP with the selected channel.
- Duty routing: only the active channel's duty output is nonzero; inactive channels are driven 0.
- Ramp arithmetic: 8-bit, never wraps; the comparisons above guarantee saturation at 0 and DUTY_MAX.
- Per-channel period: 2*(DUTY_MAX+1) + 2*HOLD_STEPS ticks.
- channel_mask timing: sampled only at IDLE exit and at HOLD_LOW exit. Mid-ramp mask changes do not abort the current channel.
- enable low in any state: next clock goes to IDLE, duties 0, prescaler 0, no cycle_done pulse.
- enable and tick in the same clock: the enable-low transition wins.
- Asynchronous reset mid-operation returns immediately to the reset values; no partial pulse is emitted.

Optional Feature:
- Macro: LED_FADE_PWM_EN.
- Defined:
  - Adds outputs led_red, led_green and led_blue (1 bit each, active-low: 0 = LED on).
  - Driven from an internal free-running 8-bit PWM counter on clock_12mhz: led_x = !(pwm_count < duty_x).
  - Outputs are registered; reset value is 1 (all LEDs off).
  - Duty 0 gives constant 1; duty 255 gives 1 for exactly 1 of every 256 clocks.
- Not defined: these ports and the PWM counter do not exist; duty outputs only.

Decomposition:
- Shared package led_fade_pkg:
  - state enum: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
  - channel index constants: CH_RED = 0, CH_GREEN = 1, CH_BLUE = 2.
  - DUTY_W = 8.
- Sub-module fade_tick_gen:
  - Parameterised by CLK_DIV.
  - Inputs: clock_12mhz, reset, clear. Output: tick.
- The FSM, hold counter, duty registers and optional PWM stay in led_fade_sequencer.

Test Plan:
All scenarios use CLK_DIV=4, HOLD_STEPS=2, DUTY_MAX=3 unless stated.
1. Reset asserted mid-RAMP_UP with duty_red=2 -> same clock: all duties 0, busy 0, LED outputs 1.
2. enable=1, mask=3'b111 from reset:
   - duty_red steps 0,1,2,3 on ticks 1-3, then holds and ramps down.
   - active_channel goes 0 -> 1 at tick 12, 1 -> 2 at tick 24.
   - cycle_done pulses exactly once at tick 36.
3. mask=3'b100 -> only duty_blue ever nonzero; cycle_done pulses every 12 ticks; active_channel stays 2.
4. mask=3'b000 with enable=1 -> busy stays 0, all duties 0 indefinitely.
5. enable dropped at duty_green=2 in RAMP_DOWN -> next clock: IDLE, all duties 0, no cycle_done.
6. LED_FADE_PWM_EN defined, DUTY_MAX=255, duty_red frozen at 64 -> led_red = 0 for exactly 64 of each 256 clocks.
